sdram_wb_arbiter: RTL and testbench

SDRAM_WB_ARBITER -- requirements
Module: sdram_wb_arbiter

---
 rtl/sdram_wb_arbiter_pkg.sv | 16 +
 rtl/sdram_wb_arbiter_rr_pick.sv | 23 ++
 rtl/sdram_wb_arbiter.sv | 175 +++++++++++++++++
 tb/tb_sdram_wb_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_wb_arbiter_pkg.sv
// Shared types and constants for the SDRAM-controller Wishbone arbiter.
package sdram_pkg;

  localparam int WB_DATA_W      = 32;
  localparam int WB_SEL_W       = 4;
  localparam int DEFAULT_ADDR_W = 25;

  // Arbiter FSM: waiting for a requester, forwarding one owner, or
  // collecting the owner's remaining acks before handing over.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_DRAIN = 2'd2
  } arb_state_e;

endpackage

// File: rtl/sdram_wb_arbiter_rr_pick.sv
// Rotating-priority selector: one-hot grant for the first requester found
// at or after ptr, wrapping around modulo N.
module rr_pick #(
  parameter int N     = 3,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt
);

  // Scan from the farthest offset down so the nearest requester wins last.
  always_comb begin
    gnt = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[IDX_W'((int'(ptr) + k) % N)]) begin
        gnt = '0;
        gnt[IDX_W'((int'(ptr) + k) % N)] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sdram_wb_arbiter.sv
// Round-robin arbiter sharing one pipelined Wishbone SDRAM-controller port
// among NUM_MASTERS requesters, with burst limiting and outstanding-ack
// tracking. Request and response paths are combinational once granted.
module sdram_wb_arbiter
  import sdram_pkg::*;
#(
  parameter int NUM_MASTERS = 3,
  parameter int ADDR_W      = DEFAULT_ADDR_W,
  parameter int MAX_BURST   = 16,
  parameter int MAX_OUTST   = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_MASTERS-1:0]           m_cyc,
  input  logic [NUM_MASTERS-1:0]           m_stb,
  input  logic [NUM_MASTERS-1:0]           m_we,
  input  logic [NUM_MASTERS*ADDR_W-1:0]    m_addr,
  input  logic [NUM_MASTERS*WB_DATA_W-1:0] m_wdata,
  input  logic [NUM_MASTERS*WB_SEL_W-1:0]  m_sel,
  output logic [NUM_MASTERS-1:0]           m_ack,
  output logic [NUM_MASTERS-1:0]           m_stall,
  output logic [WB_DATA_W-1:0]             m_rdata,
  output logic                             s_cyc,
  output logic                             s_stb,
  output logic                             s_we,
  output logic [ADDR_W-1:0]                s_addr,
  output logic [WB_DATA_W-1:0]             s_wdata,
  output logic [WB_SEL_W-1:0]              s_sel,
  input  logic                             s_ack,
  input  logic                             s_stall,
  input  logic [WB_DATA_W-1:0]             s_rdata,
  output logic [NUM_MASTERS-1:0]           grant,
  output logic                             busy
);

  localparam int IDX_W   = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int BURST_W = $clog2(MAX_BURST + 1);
  localparam int OUTST_W = $clog2(MAX_OUTST + 1);
  localparam logic [BURST_W-1:0] BURST_LIMIT = BURST_W'(MAX_BURST);
  localparam logic [OUTST_W-1:0] OUTST_LIMIT = OUTST_W'(MAX_OUTST);
  localparam logic [IDX_W-1:0]   LAST_IDX    = IDX_W'(NUM_MASTERS - 1);

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   g_q, g_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
  logic [OUTST_W-1:0] outst_cnt_q, outst_cnt_d;

  logic [NUM_MASTERS-1:0] pick_onehot;
  logic [IDX_W-1:0]       pick_idx;
  logic                   blocked;
  logic                   accept;
  logic                   ack_cnt;
  logic                   others_req;

  // Per-master views of the flattened buses, indexed by the owner.
  logic [ADDR_W-1:0]    addr_arr  [NUM_MASTERS];
  logic [WB_DATA_W-1:0] wdata_arr [NUM_MASTERS];
  logic [WB_SEL_W-1:0]  sel_arr   [NUM_MASTERS];

  for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_unpack
    assign addr_arr[i]  = m_addr[i*ADDR_W +: ADDR_W];
    assign wdata_arr[i] = m_wdata[i*WB_DATA_W +: WB_DATA_W];
    assign sel_arr[i]   = m_sel[i*WB_SEL_W +: WB_SEL_W];
  end

  rr_pick #(
    .N     (NUM_MASTERS),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req (m_cyc),
    .ptr (rr_ptr_q),
    .gnt (pick_onehot)
  );

  // One-hot to index for the winner of the rotating scan.
  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (pick_onehot[i]) pick_idx = IDX_W'(i);
    end
  end

  assign blocked    = (outst_cnt_q == OUTST_LIMIT) || (burst_cnt_q == BURST_LIMIT);
  assign accept     = s_stb && !s_stall;
  // Acks with nothing outstanding, or while idle, never touch the counter.
  assign ack_cnt    = s_ack && (state_q != ST_IDLE) && (outst_cnt_q != '0);
  assign others_req = |(m_cyc & ~grant);
  assign busy       = (state_q != ST_IDLE);
  assign m_rdata    = s_rdata;

  // Combinational routing between the owner and the controller port.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no latch is inferred.
    grant   = '0;
    m_ack   = '0;
    m_stall = '1;
    s_cyc   = 1'b0;
    s_stb   = 1'b0;
    s_we    = m_we[g_q];
    s_addr  = addr_arr[g_q];
    s_wdata = wdata_arr[g_q];
    s_sel   = sel_arr[g_q];
    case (state_q)
      ST_GRANT: begin
        grant[g_q]   = 1'b1;
        s_cyc        = m_cyc[g_q];
        s_stb        = m_stb[g_q] && !blocked;
        m_stall[g_q] = s_stall || blocked;
        m_ack[g_q]   = s_ack;
      end
      ST_DRAIN: begin
        grant[g_q] = 1'b1;
        s_cyc      = (outst_cnt_q != '0);
        m_ack[g_q] = s_ack;
      end
      default: ;
    endcase
  end

  // Next-state, ownership and counter updates.
  always_comb begin
    state_d     = state_q;
    g_d         = g_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q + BURST_W'(accept);
    outst_cnt_d = outst_cnt_q + OUTST_W'(accept) - OUTST_W'(ack_cnt);
    case (state_q)
      ST_IDLE: begin
        burst_cnt_d = '0;
        outst_cnt_d = '0;
        if (|m_cyc) begin
          g_d     = pick_idx;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (!m_cyc[g_q] || (burst_cnt_q == BURST_LIMIT && others_req)) begin
          state_d = ST_DRAIN;
        end else if (burst_cnt_q == BURST_LIMIT) begin
          // Nobody else is waiting: start a fresh burst for the same owner.
          burst_cnt_d = '0;
        end
      end
      ST_DRAIN: begin
        if (outst_cnt_d == '0) begin
          state_d     = ST_IDLE;
          rr_ptr_d    = (g_q == LAST_IDX) ? '0 : g_q + 1'b1;
          burst_cnt_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Arbiter state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: only control state is reset; the data path is a pure passthrough with no storage.
      state_q     <= ST_IDLE;
      g_q         <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
      outst_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      state_q     <= state_d;
      g_q         <= g_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
      outst_cnt_q <= outst_cnt_d;
    end
  end

endmodule

// File: tb/tb_sdram_wb_arbiter.sv
// Directed self-checking bench for sdram_wb_arbiter (3 masters, 25-bit
// addresses, burst limit 16, 4 outstanding).
module tb_sdram_wb_arbiter;

  localparam int N  = 3;
  localparam int AW = 25;

  logic          clk;
  logic          rst_n;
  logic [N-1:0]  m_cyc, m_stb, m_we;
  logic [N*AW-1:0] m_addr;
  logic [N*32-1:0] m_wdata;
  logic [N*4-1:0]  m_sel;
  logic [N-1:0]  m_ack, m_stall;
  logic [31:0]   m_rdata;
  logic          s_cyc, s_stb, s_we;
  logic [AW-1:0] s_addr;
  logic [31:0]   s_wdata;
  logic [3:0]    s_sel;
  logic          s_ack, s_stall;
  logic [31:0]   s_rdata;
  logic [N-1:0]  grant;
  logic          busy;

  int total = 0;
  int bad   = 0;

  sdram_wb_arbiter #(
    .NUM_MASTERS (N),
    .ADDR_W      (AW),
    .MAX_BURST   (16),
    .MAX_OUTST   (4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .m_cyc   (m_cyc),
    .m_stb   (m_stb),
    .m_we    (m_we),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_sel   (m_sel),
    .m_ack   (m_ack),
    .m_stall (m_stall),
    .m_rdata (m_rdata),
    .s_cyc   (s_cyc),
    .s_stb   (s_stb),
    .s_we    (s_we),
    .s_addr  (s_addr),
    .s_wdata (s_wdata),
    .s_sel   (s_sel),
    .s_ack   (s_ack),
    .s_stall (s_stall),
    .s_rdata (s_rdata),
    .grant   (grant),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_grant"},   32'(grant),   32'h0);
    check({pfx, "_busy"},    32'(busy),    32'h0);
    check({pfx, "_s_cyc"},   32'(s_cyc),   32'h0);
    check({pfx, "_s_stb"},   32'(s_stb),   32'h0);
    check({pfx, "_m_ack"},   32'(m_ack),   32'h0);
    check({pfx, "_m_stall"}, 32'(m_stall), 32'h7);
  endtask

  // Advance until grant equals want, bounded by budget cycles.
  task automatic wait_grant(input logic [N-1:0] want, input int budget, input string tag);
    for (int c = 0; c < budget; c++) begin
      step();
      settle();
      if (grant === want) break;
    end
    check(tag, 32'(grant), 32'(want));
  endtask

  task automatic wait_idle(input int budget, input string tag);
    for (int c = 0; c < budget; c++) begin
      step();
      settle();
      if (busy === 1'b0) break;
    end
    check(tag, 32'(busy), 32'h0);
  endtask

  int          n_acc;
  int          ack_seen;
  int          fwd, acks1, issued;
  logic        ack_next, done;
  logic [AW-1:0] mem_addr, rd_addr;
  logic [31:0] mem_word;

  initial begin
    rst_n = 1'b0; m_cyc = '0; m_stb = '0; m_we = '0;
    m_addr = '0; m_wdata = '0; m_sel = '0;
    s_ack = 1'b1; s_stall = 1'b0; s_rdata = '0;
    mem_addr = '0; mem_word = '0; rd_addr = '0;
    #3;
    check_reset_outputs("reset");
    step();
    step();
    rst_n = 1'b1;
    s_ack = 1'b0;

    // Masters 0 and 2 request together: 0 first, then 2.
    m_cyc = 3'b101;
    settle();
    check("idle_no_grant_yet", 32'(grant), 32'h0);
    step();
    settle();
    check("first_grant_m0", 32'(grant), 32'h1);
    check("first_busy", 32'(busy), 32'h1);
    check("first_stall", 32'(m_stall), 32'h6);
    check("first_s_cyc", 32'(s_cyc), 32'h1);
    m_cyc = 3'b100;
    settle();
    check("drop_s_cyc", 32'(s_cyc), 32'h0);
    wait_grant(3'b100, 10, "rr_next_m2");
    m_cyc = 3'b000;
    wait_idle(10, "m2_release_idle");

    // Controller never acks: only 4 of 6 strobes get through.
    m_cyc = 3'b001; m_stb = 3'b001; m_we = 3'b000;
    m_addr[0*AW +: AW] = 25'h20;
    wait_grant(3'b001, 10, "outst_grant_m0");
    n_acc = 0;
    for (int c = 0; c < 6; c++) begin
      if (s_stb && !s_stall) n_acc++;
      check($sformatf("outst_stall_c%0d", c), 32'(m_stall[0]), (c < 4) ? 32'h0 : 32'h1);
      step();
      settle();
    end
    check("outst_accepted", 32'(n_acc), 32'd4);
    s_ack = 1'b1;
    settle();
    check("outst_stall_during_ack", 32'(m_stall[0]), 32'h1);
    check("outst_m_ack", 32'(m_ack), 32'h1);
    step(); s_ack = 1'b0; settle();
    check("outst_5th_stb", 32'(s_stb), 32'h1);
    check("outst_5th_unstalled", 32'(m_stall[0]), 32'h0);
    step(); s_ack = 1'b1; settle();
    check("outst_reblocked", 32'(m_stall[0]), 32'h1);
    step(); s_ack = 1'b0; settle();
    check("outst_6th_stb", 32'(s_stb), 32'h1);
    step(); m_stb = 3'b000; s_ack = 1'b1; settle();
    check("outst_ack_b", 32'(m_ack), 32'h1);

    // Owner leaves with 3 outstanding: drain them, no new strobes.
    step(); s_ack = 1'b0; m_cyc = 3'b000; settle();
    check("drop_no_stb", 32'(s_stb), 32'h0);
    step();
    m_stb = 3'b001;
    s_ack = 1'b1;
    ack_seen = 0;
    for (int c = 0; c < 3; c++) begin
      settle();
      check($sformatf("drain_s_stb_%0d", c), 32'(s_stb), 32'h0);
      check($sformatf("drain_s_cyc_%0d", c), 32'(s_cyc), 32'h1);
      check($sformatf("drain_stall_%0d", c), 32'(m_stall), 32'h7);
      if (m_ack === 3'b001) ack_seen++;
      step();
    end
    s_ack = 1'b0; m_stb = 3'b000;
    settle();
    check("drain_acks", 32'(ack_seen), 32'd3);
    check("drain_then_idle", 32'(busy), 32'h0);
    check("drain_idle_s_cyc", 32'(s_cyc), 32'h0);

    // Master 1 streams 20 reads while master 0 waits.
    m_cyc = 3'b011; m_stb = 3'b010; m_we = 3'b000;
    m_addr[1*AW +: AW] = 25'h100;
    wait_grant(3'b010, 10, "burst_grant_m1");
    fwd = 0; acks1 = 0; issued = 0; ack_next = 1'b0; done = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      s_ack = ack_next;
      m_stb[1] = (issued < 20);
      settle();
      if (grant === 3'b001) begin
        done = 1'b1;
      end else begin
        if (s_stb && !s_stall) fwd++;
        if (m_ack[1]) acks1++;
        ack_next = s_stb && !s_stall;
        if (m_stb[1] && !m_stall[1]) issued++;
        step();
      end
    end
    s_ack = 1'b0;
    check("burst_handover_m0", 32'(done), 32'h1);
    check("burst_forwarded", 32'(fwd), 32'd16);
    check("burst_issued", 32'(issued), 32'd16);
    check("burst_acks_m1", 32'(acks1), 32'd16);

    // Write through master 0, read back through master 1.
    m_cyc = 3'b001; m_stb = 3'b001; m_we = 3'b001;
    m_addr[0*AW +: AW] = 25'h10;
    m_wdata[0*32 +: 32] = 32'hA5A5_1234;
    m_sel[0*4 +: 4] = 4'hF;
    settle();
    check("wr_s_stb", 32'(s_stb), 32'h1);
    check("wr_s_we", 32'(s_we), 32'h1);
    check("wr_s_addr", 32'(s_addr), 32'h10);
    check("wr_s_wdata", s_wdata, 32'hA5A5_1234);
    check("wr_s_sel", 32'(s_sel), 32'hF);
    if (s_stb && !s_stall && s_we) begin
      mem_addr = s_addr;
      mem_word = s_wdata;
    end
    step(); m_stb = 3'b000; s_ack = 1'b1; settle();
    check("wr_ack_m0", 32'(m_ack), 32'h1);
    step();
    s_ack = 1'b0;
    m_cyc = 3'b010; m_stb = 3'b010; m_we = 3'b000;
    m_addr[1*AW +: AW] = 25'h10;
    m_sel[1*4 +: 4] = 4'hF;
    wait_grant(3'b010, 10, "rd_grant_m1");
    check("rd_s_addr", 32'(s_addr), 32'h10);
    check("rd_s_we", 32'(s_we), 32'h0);
    check("rd_s_stb", 32'(s_stb), 32'h1);
    rd_addr = s_addr;
    step();
    m_stb = 3'b000;
    s_ack = 1'b1;
    s_rdata = (rd_addr == mem_addr) ? mem_word : 32'hDEAD_BEEF;
    settle();
    check("rd_m_rdata", m_rdata, 32'hA5A5_1234);
    check("rd_ack_only_m1", 32'(m_ack), 32'h2);

    // Reset while master 1 has two strobes outstanding.
    step(); s_ack = 1'b0; m_stb = 3'b010; settle();
    step(); settle();
    step(); m_stb = 3'b000;
    rst_n = 1'b0;
    s_ack = 1'b1;
    settle();
    check_reset_outputs("midrst");
    step();
    rst_n = 1'b1;
    m_cyc = 3'b000;
    settle();
    check("late_ack_dropped", 32'(m_ack), 32'h0);
    check("post_rst_idle", 32'(busy), 32'h0);
    s_ack = 1'b0;
    m_cyc = 3'b101;
    wait_grant(3'b001, 10, "post_rst_rr_ptr0");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
